// File: rtl/led_pattern_blinker.sv
// led_pattern_blinker: multi-channel LED driver with a shared 1 kHz prescaler
// and per-channel OFF/ON/BLINK/BURST pattern generation.
module led_pattern_blinker #(
  parameter int NUM_CH    = 4,
  parameter int TICK_DIV  = 25,
  parameter int HP0       = 5,
  parameter int HP1       = 10,
  parameter int HP2       = 50,
  parameter int HP3       = 500,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 3,
  parameter int BURST_GAP = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2*NUM_CH-1:0]   rate,
  input  logic [2*NUM_CH-1:0]   mode,
  output logic [NUM_CH-1:0]     led_out,
  output logic                  tick
);
  localparam int PRE_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BL_W  = $clog2(BURST_LEN + 1);
  localparam int GP_W  = $clog2(BURST_GAP + 1);
  typedef enum logic {BLINK_ST, GAP_ST} state_t;
  logic [PRE_W-1:0]  r_pre;
  logic [NUM_CH-1:0] w_phase;
  assign tick = r_pre == PRE_W'(TICK_DIV - 1);
  always_ff @(posedge clock) begin
    if (reset) r_pre <= '0;
    else r_pre <= tick ? '0 : r_pre + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) led_out <= '0;
    else led_out <= enable ? w_phase : '0;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n, w_hp_m1;
    logic [BL_W-1:0]  r_bcnt, w_bcnt_n;
    logic [GP_W-1:0]  r_gcnt, w_gcnt_n;
    logic [1:0]       r_rate_q, r_mode_q;
    logic             r_phase, w_phase_n, w_chg, w_hp_end;
    assign w_chg    = {rate[2*c+:2], mode[2*c+:2]} != {r_rate_q, r_mode_q};
    assign w_hp_m1  = r_rate_q[1] ? (r_rate_q[0] ? CNT_W'(HP3 - 1) : CNT_W'(HP2 - 1))
                                  : (r_rate_q[0] ? CNT_W'(HP1 - 1) : CNT_W'(HP0 - 1));
    assign w_hp_end = tick && r_cnt == w_hp_m1;
    assign w_phase[c] = r_phase;
    always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_phase_n = r_phase;
      w_bcnt_n  = r_bcnt;
      w_gcnt_n  = r_gcnt;
      if (w_chg) begin
        w_state_n = BLINK_ST;
        w_cnt_n   = '0;
        w_phase_n = 1'b0;
        w_bcnt_n  = '0;
      end else begin
        if (tick) w_cnt_n = w_hp_end ? '0 : r_cnt + 1'b1;
        case (r_mode_q)
          2'b00: w_phase_n = 1'b0;
          2'b01: w_phase_n = 1'b1;
          2'b10: w_phase_n = w_hp_end ? ~r_phase : r_phase;
          default: begin
            if (r_state == GAP_ST) begin
              w_phase_n = 1'b0;
              if (w_hp_end) begin
                w_gcnt_n = r_gcnt + 1'b1;
                if (r_gcnt == GP_W'(BURST_GAP - 1)) w_state_n = BLINK_ST;
              end
            end else if (w_hp_end) begin
              w_phase_n = ~r_phase;
              // A completed on/off cycle is counted on the falling half-period edge
              if (r_phase) begin
                w_bcnt_n = r_bcnt + 1'b1;
                if (r_bcnt == BL_W'(BURST_LEN - 1)) begin
                  w_bcnt_n  = '0;
                  w_gcnt_n  = '0;
                  w_state_n = GAP_ST;
                end
              end
            end
          end
        endcase
      end
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        r_state  <= BLINK_ST;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
        r_bcnt   <= '0;
        r_gcnt   <= '0;
        r_rate_q <= '0;
        r_mode_q <= '0;
      end else begin
        r_state  <= w_state_n;
        r_cnt    <= w_cnt_n;
        r_phase  <= w_phase_n;
        r_bcnt   <= w_bcnt_n;
        r_gcnt   <= w_gcnt_n;
        r_rate_q <= rate[2*c+:2];
        r_mode_q <= mode[2*c+:2];
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_blinker.sv
// tb_led_pattern_blinker: directed checks of prescaler, blink/burst timing,
// config restart, enable gating and reset for led_pattern_blinker.
module tb_led_pattern_blinker;
  logic       clock, reset, enable, tick;
  logic [7:0] rate, mode;
  logic [3:0] led_out;
  int checks = 0;
  int errors = 0;
  int ec = 0;
  led_pattern_blinker dut (
    .clock(clock), .reset(reset), .enable(enable), .rate(rate),
    .mode(mode), .led_out(led_out), .tick(tick)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic run_to(input int t);
    while (ec < t) begin
      @(posedge clock);
      #1;
      ec++;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, ec, got, exp);
    end
  endtask
  task automatic hold_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst_led", 32'(led_out), 0);
      chk("rst_tick", 32'(tick), 0);
    end
    reset = 1'b0;
    ec = 0;
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    mode = 8'b10_01_11_10;
    rate = 8'b10_01_00_00;
    hold_reset();
    run_to(2);     chk("ch2_on_pre", 32'(led_out[2]), 0);
    run_to(3);     chk("ch2_on", 32'(led_out[2]), 1);
    run_to(23);    chk("tick23", 32'(tick), 0);
    run_to(24);    chk("tick24", 32'(tick), 1);
    run_to(25);    chk("tick25", 32'(tick), 0);
    run_to(125);   chk("leds125", 32'(led_out), 32'b0100);
    run_to(126);   chk("leds126", 32'(led_out), 32'b0111);
    run_to(250);   chk("leds250", 32'(led_out), 32'b0111);
    run_to(251);   chk("leds251", 32'(led_out), 32'b0100);
    run_to(376);   chk("leds376", 32'(led_out), 32'b0111);
    run_to(400);   chk("ch0_high400", 32'(led_out[0]), 1);
    rate = 8'b10_01_00_01;
    run_to(401);   chk("ch0_rchg401", 32'(led_out[0]), 1);
    run_to(402);   chk("ch0_rchg402", 32'(led_out[0]), 0);
    run_to(626);   chk("ch1_p3_626", 32'(led_out[1]), 1);
    run_to(650);   chk("ch0_r1_650", 32'(led_out[0]), 0);
    run_to(651);   chk("ch0_r1_651", 32'(led_out[0]), 1);
    run_to(750);   chk("ch1_p3_750", 32'(led_out[1]), 1);
    run_to(751);   chk("ch1_gap751", 32'(led_out[1]), 0);
    run_to(1250);  chk("ch3_1250", 32'(led_out[3]), 0);
    run_to(1251);  chk("ch3_1251", 32'(led_out[3]), 1);
    run_to(1300);  chk("leds1300", 32'(led_out), 32'b1101);
    enable = 1'b0;
    run_to(1301);  chk("dis1301", 32'(led_out), 0);
    run_to(1400);  chk("dis1400", 32'(led_out), 0);
    enable = 1'b1;
    run_to(1401);  chk("reen1401", 32'(led_out), 32'b1110);
    run_to(1651);  chk("ch0_1651", 32'(led_out[0]), 1);
    run_to(2625);  chk("ch1_2625", 32'(led_out[1]), 0);
    run_to(2626);  chk("ch1_2626", 32'(led_out[1]), 1);
    mode = 8'b10_00_11_10;
    run_to(2627);  chk("ch2_off2627", 32'(led_out[2]), 1);
                   chk("ch3_2627", 32'(led_out[3]), 0);
    run_to(2628);  chk("ch2_off2628", 32'(led_out[2]), 0);
    run_to(3751);  chk("ch3_3751", 32'(led_out[3]), 1);
    run_to(3875);  chk("ch1_3875", 32'(led_out[1]), 0);
    run_to(3876);  chk("ch1_3876", 32'(led_out[1]), 1);
    rate = 8'b10_01_00_11;
    run_to(3877);  chk("ch0_3877", 32'(led_out[0]), 1);
    run_to(3878);  chk("ch0_3878", 32'(led_out[0]), 0);
    run_to(16375); chk("ch0_1hz_lo", 32'(led_out[0]), 0);
    run_to(16376); chk("ch0_1hz_rise", 32'(led_out[0]), 1);
    chk("ch2_still_off", 32'(led_out[2]), 0);
    run_to(28875); chk("ch0_1hz_hi", 32'(led_out[0]), 1);
    run_to(28876); chk("ch0_1hz_fall", 32'(led_out[0]), 0);
    hold_reset();
    run_to(24);    chk("tick_after_rst", 32'(tick), 1);
    run_to(125);   chk("leds_rst125", 32'(led_out), 0);
    run_to(126);   chk("leds_rst126", 32'(led_out), 32'b0010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
